// File: rtl/clkgate_ctrl_pkg.sv
// Shared types and constants for the multi-channel clock-gating controller.
// Channel FSM encoding, wake counter width and the channel-count ceiling.
package clkgate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } ch_state_t;

    localparam int WAKE_CNT_W = 4;
    localparam int MAX_CH     = 16;

endpackage

// File: rtl/OPENROAD_CTRLGATE.sv
// Behavioural model of the latch-based integrated clock gate cell.
// Enable is captured while CK is low, so GCK can only ever carry whole CK high phases.
module OPENROAD_CTRLGATE (
    input  logic CK,
    input  logic E,
    output logic GCK
);

    logic en_lat_r;

    // Transparent-low enable latch: opaque for the whole CK high phase.
    always_latch begin
        if (!CK) begin
            en_lat_r <= E;
        end
    end

    assign GCK = CK & en_lat_r;

endmodule

// File: rtl/clkgate_ctrl_ch.sv
// One gated-clock channel: req/ack handshake FSM, wake and drain counters,
// registered ack/busy/enable and the glitch-free gate cell driving GCK.
module clkgate_ctrl_ch #(
    parameter int WAKE_CYC = 2,
    parameter int HOLD_W   = 4
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              req,
    input  logic [HOLD_W-1:0] hold,
    input  logic              force_on,
    input  logic              test_en,
    output logic              ack,
    output logic              busy,
    output logic              GCK
);

    import clkgate_ctrl_pkg::*;

    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYC - 1);

    ch_state_t               state_r;
    ch_state_t               state_nxt_s;
    logic [WAKE_CNT_W-1:0]   wake_cnt_r;
    logic [WAKE_CNT_W-1:0]   wake_cnt_nxt_s;
    logic [HOLD_W-1:0]       drain_cnt_r;
    logic [HOLD_W-1:0]       drain_cnt_nxt_s;
    logic                    ack_r;
    logic                    busy_r;
    logic                    en_r;

    // Next-state and counter logic; the drain count is latched from hold only on entry.
    always_comb begin
        state_nxt_s     = state_r;
        wake_cnt_nxt_s  = wake_cnt_r;
        drain_cnt_nxt_s = drain_cnt_r;
        case (state_r)
            ST_OFF: begin
                if (req) begin
                    state_nxt_s    = ST_WAKE;
                    wake_cnt_nxt_s = WAKE_LOAD;
                end else begin
                    state_nxt_s    = ST_OFF;
                end
            end
            ST_WAKE: begin
                if (!req) begin
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = hold;
                end else if (wake_cnt_r == {WAKE_CNT_W{1'b0}}) begin
                    state_nxt_s     = ST_ON;
                end else begin
                    wake_cnt_nxt_s  = wake_cnt_r - WAKE_CNT_W'(1);
                end
            end
            ST_ON: begin
                if (!req) begin
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = hold;
                end else begin
                    state_nxt_s     = ST_ON;
                end
            end
            ST_DRAIN: begin
                // Clock is still running here, so a re-request skips the wake delay.
                if (req) begin
                    state_nxt_s     = ST_ON;
                end else if (drain_cnt_r == {HOLD_W{1'b0}}) begin
                    state_nxt_s     = ST_OFF;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - HOLD_W'(1);
                end
            end
            default: begin
                state_nxt_s     = ST_OFF;
                wake_cnt_nxt_s  = {WAKE_CNT_W{1'b0}};
                drain_cnt_nxt_s = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs; outputs derive from the next state
    // so ack, busy and the gate enable share one edge of latency with the FSM.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_r     <= ST_OFF;
            wake_cnt_r  <= {WAKE_CNT_W{1'b0}};
            drain_cnt_r <= {HOLD_W{1'b0}};
            ack_r       <= 1'b0;
            busy_r      <= 1'b0;
            en_r        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wake_cnt_r  <= wake_cnt_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            ack_r       <= (state_nxt_s == ST_ON);
            busy_r      <= (state_nxt_s != ST_OFF);
            en_r        <= (state_nxt_s != ST_OFF) | force_on | test_en;
        end
    end

    assign ack  = ack_r;
    assign busy = busy_r;

    OPENROAD_CTRLGATE u_gate (
        .CK  (CK),
        .E   (en_r),
        .GCK (GCK)
    );

endmodule

// File: rtl/clkgate_ctrl.sv
// Multi-channel clock-gating controller: N_CH independent gated clocks, each with
// its own handshake FSM; busy reports any channel not in OFF.
module clkgate_ctrl #(
    parameter int N_CH     = 4,
    parameter int WAKE_CYC = 2,
    parameter int HOLD_W   = 4
) (
    input  logic              CK,
    input  logic              RN,
    input  logic [N_CH-1:0]   req,
    input  logic [HOLD_W-1:0] hold,
    input  logic              force_on,
    input  logic              test_en,
    output logic [N_CH-1:0]   ack,
    output logic [N_CH-1:0]   GCK,
    output logic              busy
);

    import clkgate_ctrl_pkg::*;

    logic [N_CH-1:0] busy_s;

    if ((N_CH < 1) || (N_CH > MAX_CH)) begin : g_bad_n_ch
        $error("clkgate_ctrl: N_CH out of range");
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        clkgate_ctrl_ch #(
            .WAKE_CYC (WAKE_CYC),
            .HOLD_W   (HOLD_W)
        ) u_ch (
            .CK       (CK),
            .RN       (RN),
            .req      (req[ch]),
            .hold     (hold),
            .force_on (force_on),
            .test_en  (test_en),
            .ack      (ack[ch]),
            .busy     (busy_s[ch]),
            .GCK      (GCK[ch])
        );
    end

    // Each term is already registered inside its channel.
    assign busy = |busy_s;

endmodule

// File: doc/clkgate_ctrl.md
# clkgate_ctrl

Multi-channel clock-gating controller for the TSMC65 flow. It generalises the single fixed OPENROAD_CTRLGATE mapping into N_CH independently managed gated clocks. Each channel uses a req/ack handshake, a programmable wake-up delay, and a programmable drain (hold-off) time. Sits between the digital sequencer and the gated sub-blocks (ADC slices, readout shift registers); every gated output is produced by one OPENROAD_CTRLGATE instance, so gating stays glitch-free.

## Interface

Parameters:
- N_CH, 4, number of gated clock channels (1..16)
- WAKE_CYC, 2, cycles the clock runs before ack rises (1..15)
- HOLD_W, 4, width of the drain-length input

Ports:
- CK  input  1  free-running source clock
- RN  input  1  asynchronous active-low reset
- req  input  N_CH  per-channel clock request, level, synchronous to CK
- hold  input  HOLD_W  drain length in cycles, shared by all channels
- force_on  input  1  enables all gates regardless of state; FSMs unaffected
- test_en  input  1  scan bypass; same effect as force_on
- ack  output  N_CH  per-channel clock-stable acknowledge
- GCK  output  N_CH  gated clocks
- busy  output  1  OR over channels of (state != OFF)

## Operation

Per-channel FSM. States are OFF, WAKE, ON and DRAIN. Reset state is OFF.
- OFF -> WAKE when req=1. A wake counter loads WAKE_CYC-1.
- WAKE: counter decrements each cycle.
  - At 0 with req=1 -> ON.
  - req=0 at any point -> DRAIN.
- ON: ack=1.
  - req=0 -> DRAIN. The drain counter loads the value of hold sampled on that edge.
- DRAIN: counter decrements each cycle.
  - req=1 -> ON directly, with no wake delay, because the clock is still running.
  - Counter at 0 with req=0 -> OFF. With hold=0, DRAIN lasts exactly 1 cycle.
- Changes to hold during DRAIN do not affect the running count.
- Gate enable per channel is a registered signal: en = (state != OFF) | force_on | test_en. It feeds the E pin of that channel's OPENROAD_CTRLGATE; CK feeds CK.
- ack is registered and equals (state == ON).
- Channels are fully independent. Simultaneous requests on all channels are legal and need no arbitration.

Reset values (RN low): all FSMs OFF, counters 0, ack=0, busy=0, en=0, GCK=0.
- Reset asserted mid-operation: a GCK high phase already in progress completes, because the latch is opaque while CK is high. No further GCK pulses occur. No runt pulse is allowed.
- Reset release: first state change occurs on the first CK rising edge with RN high.

## Timing

- req sampled high at rising edge k:
  - State becomes WAKE after edge k.
  - First GCK rising edge is at edge k+1.
  - ack=1 after edge k+WAKE_CYC.
- req low at edge m while in ON:
  - ack=0 after edge m.
  - GCK continues through edge m+hold+1.
  - State is OFF after edge m+hold+1; first suppressed edge is m+hold+2.
- force_on/test_en take effect on GCK one rising edge after being sampled.
- busy is registered and tracks state with the same one-edge latency as ack.

## Structure

- Package clkgate_ctrl_pkg holds:
  - the state enum (OFF, WAKE, ON, DRAIN; 2-bit encoding)
  - the wake counter width, 4 bits
  - the maximum channel count constant, 16
- Sub-module clkgate_ctrl_ch contains one channel's FSM, its counters, its ack/en registers and its OPENROAD_CTRLGATE instance.
- Top level generates N_CH copies of clkgate_ctrl_ch and ORs their busy terms.

## Test plan

- Reset then idle, N_CH=4: no GCK pulses; ack=0, busy=0 for 20 cycles.
- Basic handshake, WAKE_CYC=2, hold=3: req[0] high at edge 10.
  - GCK[0] first rises at edge 11; ack[0]=1 after edge 12.
  - Drop req at edge 20: ack[0]=0 after edge 20; last GCK[0] edge is 24; GCK[0] silent from edge 25.
  - Other channels stay silent throughout.
- Re-request in DRAIN, hold=5: drop req[1], re-raise it 2 cycles later.
  - Channel goes to ON; ack[1]=1 one edge after the re-raise.
  - GCK[1] never gaps.
- Abort in WAKE, WAKE_CYC=4: pulse req[2] for 1 cycle.
  - ack[2] never rises; channel passes through DRAIN for hold+1 clocks, then OFF.
- Overrides and simultaneity: all req high on the same edge, then toggle force_on and test_en with req low.
  - Acks rise together; all GCK run whenever either override is high; FSM states are unaffected.
- Async reset mid-ON: RN low during CK high.
  - Current GCK high phase completes with no glitch; ack and busy drop immediately.
  - After release with req still high, the channel restarts from WAKE with full latency.
